mei_gateway: RTL

External-interrupt gateway that sits directly upstream of the CSR block. It synchronises six asynchronous interrupt sources and applies per-source level or rising-edge triggering. Each source moves through a pending / in-service life cycle driven by a claim/complete register interface. Its o_MEI outputs drive the CSR block's i_MEI_0..i_MEI_5 inputs; the CSR block masks them with mie and raises o_IRQ.

---
 rtl/mei_gateway_pkg.sv | 39 +++
 rtl/mei_sync_filter.sv | 76 +++++++
 rtl/mei_gateway.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mei_gateway_pkg.sv
// mei_gateway_pkg: shared register map, per-source state encoding and the
// claim priority helper used by the external-interrupt gateway.
package mei_gateway_pkg;

   localparam logic [2:0] ADDR_TRIG     = 3'd0;
   localparam logic [2:0] ADDR_PEND     = 3'd1;
   localparam logic [2:0] ADDR_CLAIM    = 3'd2;
   localparam logic [2:0] ADDR_COMPLETE = 3'd3;
   localparam logic [2:0] ADDR_RAW      = 3'd4;

   localparam int CLAIM_VALID_BIT = 31;
   localparam int IDX_W           = 5;
   localparam int FILT_CNT_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PEND  = 2'd1,
      ST_INSVC = 2'd2
   } srcState_e;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } claimPick_t;

   // Lowest-index set bit wins; scanning downwards lets the last hit stand.
   function automatic claimPick_t lowestPending(input logic [30:0] pend);
      claimPick_t pick;
      pick = '0;
      for (int i = 30; i >= 0; i--) begin
         if (pend[i]) begin
            pick.valid = 1'b1;
            pick.idx   = IDX_W'(i);
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/mei_sync_filter.sv
// mei_sync_filter: one interrupt line through a SYNC_STAGES flop
// synchroniser, an optional glitch filter (MEI_GATE_FILTER_EN) and a
// previous-value flop. level_o is the level the gateway acts on, edge_o
// flags its rising edge.
module mei_sync_filter
   import mei_gateway_pkg::*;
#(
   parameter int SYNC_STAGES = 2
`ifdef MEI_GATE_FILTER_EN
   , parameter int FILTER_LEN = 4
`endif
) (
   input  logic i_CLK,
   input  logic i_RSTn,
   input  logic irq_i,
   output logic level_o,
   output logic edge_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift the raw request through the synchroniser chain.
   always_ff @(posedge i_CLK) begin
      if (!i_RSTn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
      end
   end

`ifdef MEI_GATE_FILTER_EN
   logic [FILT_CNT_W-1:0] cnt_q, cnt_d;
   logic                  filt_q, filt_d;

   // Toggle the filtered level only after FILTER_LEN disagreeing samples in a row.
   always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (sync_q[SYNC_STAGES-1] != filt_q) begin
         if (cnt_q == FILT_CNT_W'(FILTER_LEN - 1)) begin
            filt_d = ~filt_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Filter counter and filtered level registers.
   always_ff @(posedge i_CLK) begin
      if (!i_RSTn) begin
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign level_o = filt_q;
`else
   assign level_o = sync_q[SYNC_STAGES-1];
`endif

   // Remember last cycle's level so a rising edge can be detected.
   always_ff @(posedge i_CLK) begin
      if (!i_RSTn) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= level_o;
      end
   end

   assign edge_o = level_o & ~prev_q;

endmodule

// File: rtl/mei_gateway.sv
// mei_gateway: external-interrupt gateway in front of the CSR block.
// Per-source level/edge triggering, pending / in-service life cycle and a
// claim/complete register interface. Define MEI_GATE_FILTER_EN to add a
// FILTER_LEN-cycle glitch filter behind each synchroniser.
module mei_gateway
   import mei_gateway_pkg::*;
#(
   parameter int N_SRC       = 6,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic              i_CLK,
   input  logic              i_RSTn,
   input  logic [N_SRC-1:0]  i_IRQ_SRC,
   input  logic              i_BUS_EN,
   input  logic              i_BUS_WE,
   input  logic [2:0]        i_BUS_ADDR,
   input  logic [31:0]       i_BUS_WDATA,
   output logic [31:0]       o_BUS_RDATA,
   output logic              o_BUS_ACK,
   output logic [N_SRC-1:0]  o_MEI
);

`ifndef MEI_GATE_FILTER_EN
   localparam int unusedFilterLen = FILTER_LEN;
`endif

   logic [N_SRC-1:0] srcLevel;
   logic [N_SRC-1:0] srcEdge;

   srcState_e        state_q [N_SRC];
   srcState_e        state_d [N_SRC];
   logic [N_SRC-1:0] trig_q, trig_d;
   logic [N_SRC-1:0] rearm_q, rearm_d;
   logic             ack_q;
   logic [31:0]      rdata_q, rdata_d;

   logic             busRead, busWrite;
   logic [N_SRC-1:0] pendVec;
   logic [30:0]      pendWide;
   claimPick_t       pick;
   logic [N_SRC-1:0] claimHit, w1cHit, compHit;
   logic             unusedWdata;

   assign unusedWdata = ^i_BUS_WDATA;

   for (genvar g = 0; g < N_SRC; g++) begin : gSrc
      mei_sync_filter #(
         .SYNC_STAGES (SYNC_STAGES)
`ifdef MEI_GATE_FILTER_EN
         , .FILTER_LEN (FILTER_LEN)
`endif
      ) u_syncFilter (
         .i_CLK   (i_CLK),
         .i_RSTn  (i_RSTn),
         .irq_i   (i_IRQ_SRC[g]),
         .level_o (srcLevel[g]),
         .edge_o  (srcEdge[g])
      );
   end

   // Decode the bus access into per-source claim / W1C / complete strobes.
   always_comb begin
      busRead  = i_BUS_EN & ~i_BUS_WE;
      busWrite = i_BUS_EN & i_BUS_WE;
      pendVec  = '0;
      for (int n = 0; n < N_SRC; n++) begin
         pendVec[n] = (state_q[n] == ST_PEND);
      end
      pendWide             = '0;
      pendWide[N_SRC-1:0]  = pendVec;
      pick                 = lowestPending(pendWide);
      claimHit = '0;
      compHit  = '0;
      w1cHit   = '0;
      if (busWrite && (i_BUS_ADDR == ADDR_PEND)) begin
         w1cHit = i_BUS_WDATA[N_SRC-1:0] & trig_q;
      end
      for (int n = 0; n < N_SRC; n++) begin
         claimHit[n] = busRead && (i_BUS_ADDR == ADDR_CLAIM) && pick.valid
                       && (pick.idx == IDX_W'(n));
         compHit[n]  = busWrite && (i_BUS_ADDR == ADDR_COMPLETE)
                       && (i_BUS_WDATA[IDX_W-1:0] == IDX_W'(n));
      end
   end

   // Per-source life cycle and re-arm flag next state.
   always_comb begin
      state_d = state_q;
      rearm_d = rearm_q;
      for (int n = 0; n < N_SRC; n++) begin
         case (state_q[n])
            ST_IDLE: begin
               if (trig_q[n] ? srcEdge[n] : srcLevel[n]) begin
                  state_d[n] = ST_PEND;
               end
            end
            ST_PEND: begin
               if (claimHit[n]) begin
                  state_d[n] = ST_INSVC;
               end else if (!trig_q[n] && !srcLevel[n]) begin
                  state_d[n] = ST_IDLE;
               end else if (trig_q[n] && w1cHit[n] && !srcEdge[n]) begin
                  state_d[n] = ST_IDLE;
               end
            end
            ST_INSVC: begin
               if (compHit[n]) begin
                  state_d[n] = (rearm_q[n] || (trig_q[n] && srcEdge[n])) ? ST_PEND : ST_IDLE;
                  rearm_d[n] = 1'b0;
               end else if (trig_q[n] && srcEdge[n]) begin
                  rearm_d[n] = 1'b1;
               end
            end
            default: begin
               state_d[n] = ST_IDLE;
            end
         endcase
      end
      if (busWrite && (i_BUS_ADDR == ADDR_TRIG)) begin
         rearm_d = rearm_d & i_BUS_WDATA[N_SRC-1:0];
      end
   end

   // Trigger mode register update and read data selection.
   always_comb begin
      trig_d = trig_q;
      if (busWrite && (i_BUS_ADDR == ADDR_TRIG)) begin
         trig_d = i_BUS_WDATA[N_SRC-1:0];
      end
      rdata_d = '0;
      if (busRead) begin
         case (i_BUS_ADDR)
            ADDR_TRIG: rdata_d[N_SRC-1:0] = trig_q;
            ADDR_PEND: rdata_d[N_SRC-1:0] = pendVec;
            ADDR_CLAIM: begin
               if (pick.valid) begin
                  rdata_d[CLAIM_VALID_BIT] = 1'b1;
                  rdata_d[IDX_W-1:0]       = pick.idx;
               end
            end
            ADDR_RAW:  rdata_d[N_SRC-1:0] = srcLevel;
            default:   rdata_d = '0;
         endcase
      end
   end

   // Gateway state registers; reset drops all pending and in-service state.
   always_ff @(posedge i_CLK) begin
      if (!i_RSTn) begin
         for (int n = 0; n < N_SRC; n++) begin
            state_q[n] <= ST_IDLE;
         end
         trig_q  <= '0;
         rearm_q <= '0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         trig_q  <= trig_d;
         rearm_q <= rearm_d;
         ack_q   <= i_BUS_EN;
         rdata_q <= rdata_d;
      end
   end

   assign o_MEI       = pendVec;
   assign o_BUS_ACK   = ack_q;
   assign o_BUS_RDATA = rdata_q;

endmodule
